// File: rtl/p2s_serializer.sv
// Parallel-to-serial stage: accepts WIDTH-bit words on valid/ready and emits them MSB-first on x.
// Latency: a word accepted at edge k puts its MSB on x in the cycle after edge k; WIDTH cycles per word (+1 with parity).
// Backpressure: din_ready comes from registered state only; din_valid without din_ready is held off.
//
// Optional feature macro: P2S_PARITY_EN appends one odd-parity bit after each word.
//
// Ports:
//   clk        - single clock, posedge
//   rst_n      - asynchronous active-low reset
//   din        - parallel word, sampled only on the transfer edge
//   din_valid  - din holds a valid word
//   din_ready  - block accepts a word this cycle
//   x          - serial bit (0 when idle)
//   x_valid    - x carries a data or parity bit
//   last       - x holds the final bit of the current word
module p2s_serializer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             x,
    output logic             x_valid,
    output logic             last
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

`ifdef P2S_PARITY_EN
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_PARITY = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1
    } state_t;
`endif

    state_t           state_q, state_d;
    logic [WIDTH-1:0] sreg_q, sreg_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_bit;
    logic             xfer;
`ifdef P2S_PARITY_EN
    // Running XOR of the bits already emitted for the word in flight.
    logic             par_q, par_d;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            sreg_q  <= '0;
            cnt_q   <= '0;
`ifdef P2S_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
`ifdef P2S_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    always_comb begin
        state_d   = state_q;
        sreg_d    = sreg_q;
        cnt_d     = cnt_q;
`ifdef P2S_PARITY_EN
        par_d     = par_q;
`endif
        din_ready = 1'b0;
        x         = 1'b0;
        x_valid   = 1'b0;
        last      = 1'b0;
        xfer      = 1'b0;
        last_bit  = (cnt_q == CNT_LAST);

        case (state_q)
            S_IDLE: begin
                din_ready = 1'b1;
            end
            S_SHIFT: begin
                x       = sreg_q[WIDTH-1];
                x_valid = 1'b1;
                sreg_d  = sreg_q << 1;
`ifdef P2S_PARITY_EN
                par_d   = par_q ^ sreg_q[WIDTH-1];
                if (last_bit) begin
                    state_d = S_PARITY;
                    cnt_d   = cnt_q;        // hold: counter never runs past WIDTH-1
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                end
`else
                last      = last_bit;
                din_ready = last_bit;
                if (last_bit) begin
                    state_d = S_IDLE;       // overridden below by a gapless reload
                    cnt_d   = cnt_q;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                end
`endif
            end
`ifdef P2S_PARITY_EN
            S_PARITY: begin
                // Odd parity: complement the XOR so word plus parity has an odd number of ones.
                x         = ~par_q;
                x_valid   = 1'b1;
                last      = 1'b1;
                din_ready = 1'b1;
                state_d   = S_IDLE;
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A transfer wins over the return to IDLE at the end of a word.
        xfer = din_valid && din_ready;
        if (xfer) begin
            sreg_d  = din;
            cnt_d   = '0;
            state_d = S_SHIFT;
`ifdef P2S_PARITY_EN
            par_d   = 1'b0;
`endif
        end
    end

endmodule
